// File: rtl/current_window_avg_if.sv
// Sample/result bundle between the measurement controller, the ADC bus and
// the windowed current averager.
interface current_window_avg_if #(
  parameter int ADC_W = 12
) ();
  logic             measure;
  logic [ADC_W-1:0] ADC;
  logic [ADC_W-1:0] mean_curr;
  logic [ADC_W-1:0] peak_curr;
  logic [ADC_W-1:0] trough_curr;
  logic             mean_valid;
  logic             busy;

  // Controller side: requests windows, presents samples, reads results.
  modport master (
    output measure, ADC,
    input  mean_curr, peak_curr, trough_curr, mean_valid, busy
  );

  // Averager side.
  modport slave (
    input  measure, ADC,
    output mean_curr, peak_curr, trough_curr, mean_valid, busy
  );
endinterface

// File: rtl/current_window_avg.sv
// Windowed mean / peak / trough of the ADC current samples. One sample is
// accepted every DECIM cycles while measure is held; after 2^LOG2_N samples
// the result is published with a one-cycle mean_valid strobe.
module current_window_avg #(
  parameter int ADC_W  = 12,
  parameter int LOG2_N = 10,
  parameter int DECIM  = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 swiptAlive,
  current_window_avg_if.slave  bus
);

  localparam int ACC_W  = ADC_W + LOG2_N;
  localparam int CNT_W  = LOG2_N + 1;
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'((1 << LOG2_N) - 1);
  localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DECIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ACC_W-1:0]    acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [ADC_W-1:0]    max_q;
  logic [ADC_W-1:0]    min_q;
  logic [ADC_W-1:0]    mean_q;
  logic [ADC_W-1:0]    peak_q;
  logic [ADC_W-1:0]    trough_q;
  logic                valid_q;
  logic                sample_stb;

  // An abort edge (measure low) never takes a sample, even on a strobe slot.
  assign sample_stb = (state_q == ACCUM) && bus.measure && (dcnt_q == LAST_DCNT);

  // Next-state logic; a dead SWIPT heartbeat overrides everything.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.measure) state_d = ACCUM;
      end
      ACCUM: begin
        if (!bus.measure)                         state_d = IDLE;
        else if (sample_stb && cnt_q == LAST_CNT) state_d = DONE;
      end
      DONE: begin
        state_d = bus.measure ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!swiptAlive) state_d = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Window accumulation and result publication.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      max_q    <= '0;
      min_q    <= '1;
      mean_q   <= '0;
      peak_q   <= '0;
      trough_q <= '0;
      valid_q  <= 1'b0;
    end else if (!swiptAlive) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      dcnt_q   <= '0;
      max_q    <= '0;
      min_q    <= '1;
      mean_q   <= '0;
      peak_q   <= '0;
      trough_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // Outside ACCUM the running window is held cleared so that entering
      // ACCUM (from IDLE or straight from DONE) always starts fresh.
      if (state_q != ACCUM) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        dcnt_q <= '0;
        max_q  <= '0;
        min_q  <= '1;
      end else if (bus.measure) begin
        dcnt_q <= (dcnt_q == LAST_DCNT) ? '0 : dcnt_q + 1'b1;
        if (sample_stb) begin
          acc_q <= acc_q + {{LOG2_N{1'b0}}, bus.ADC};
          cnt_q <= cnt_q + 1'b1;
          if (bus.ADC > max_q) max_q <= bus.ADC;
          if (bus.ADC < min_q) min_q <= bus.ADC;
        end
      end

      // The DONE cycle sees the fully updated window; mean truncates.
      if (state_q == DONE) begin
        mean_q   <= ADC_W'(acc_q >> LOG2_N);
        peak_q   <= max_q;
        trough_q <= min_q;
        valid_q  <= 1'b1;
      end
    end
  end

  assign bus.mean_curr   = mean_q;
  assign bus.peak_curr   = peak_q;
  assign bus.trough_curr = trough_q;
  assign bus.mean_valid  = valid_q;
  assign bus.busy        = (state_q == ACCUM);

endmodule

// File: tb/tb_current_window_avg.sv
// Bench for current_window_avg: two instances (DECIM=2 and DECIM=1, both with
// 8-sample windows) share stimulus; a sample-list model predicts both every
// cycle, and directed scenarios pin latencies and results with literals.
module tb_current_window_avg;

  localparam int ADC_W = 12;
  localparam int NWIN  = 8;

  logic              clk;
  logic              nrst;
  logic              swipt_alive;
  logic              measure;
  logic [ADC_W-1:0]  adc;
  logic [ADC_W-1:0]  win [NWIN];

  int tests;
  int fails;

  current_window_avg_if #(.ADC_W(ADC_W)) if2 ();
  current_window_avg_if #(.ADC_W(ADC_W)) if1 ();

  assign if2.measure = measure;
  assign if2.ADC     = adc;
  assign if1.measure = measure;
  assign if1.ADC     = adc;

  current_window_avg #(.ADC_W(ADC_W), .LOG2_N(3), .DECIM(2)) dut2 (
    .clk        (clk),
    .nrst       (nrst),
    .swiptAlive (swipt_alive),
    .bus        (if2.slave)
  );

  current_window_avg #(.ADC_W(ADC_W), .LOG2_N(3), .DECIM(1)) dut1 (
    .clk        (clk),
    .nrst       (nrst),
    .swiptAlive (swipt_alive),
    .bus        (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0 idle, 1 collecting, 2 publishing. Samples are kept as a list and
  // reduced with ordinary arithmetic when the window completes.
  int               m_phase   [2];
  int               m_elapsed [2];
  int               m_n       [2];
  int unsigned      m_s       [2][NWIN];
  logic [ADC_W-1:0] e_mean    [2];
  logic [ADC_W-1:0] e_peak    [2];
  logic [ADC_W-1:0] e_trough  [2];
  logic             e_valid   [2];

  task automatic mdl_clear(input int i);
    m_phase[i]   = 0;
    m_elapsed[i] = 0;
    m_n[i]       = 0;
    e_mean[i]    = '0;
    e_peak[i]    = '0;
    e_trough[i]  = '0;
    e_valid[i]   = 1'b0;
  endtask

  task automatic mdl_step(input int i, input int decim);
    int unsigned sum, mx, mn;
    if (!swipt_alive) begin
      mdl_clear(i);
      return;
    end
    e_valid[i] = 1'b0;
    case (m_phase[i])
      0: if (measure) begin
        m_phase[i] = 1; m_elapsed[i] = 0; m_n[i] = 0;
      end
      1: if (!measure) begin
        m_phase[i] = 0;
      end else begin
        m_elapsed[i]++;
        if (m_elapsed[i] % decim == 0) begin
          m_s[i][m_n[i]] = adc;
          m_n[i]++;
          if (m_n[i] == NWIN) m_phase[i] = 2;
        end
      end
      default: begin
        sum = 0; mx = 0; mn = 32'hFFFF_FFFF;
        for (int k = 0; k < NWIN; k++) begin
          sum += m_s[i][k];
          if (m_s[i][k] > mx) mx = m_s[i][k];
          if (m_s[i][k] < mn) mn = m_s[i][k];
        end
        e_mean[i]   = ADC_W'(sum / NWIN);
        e_peak[i]   = ADC_W'(mx);
        e_trough[i] = ADC_W'(mn);
        e_valid[i]  = 1'b1;
        if (measure) begin
          m_phase[i] = 1; m_elapsed[i] = 0; m_n[i] = 0;
        end else begin
          m_phase[i] = 0;
        end
      end
    endcase
  endtask

  // Model advances on the same edges as the DUTs.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mdl_clear(0);
      mdl_clear(1);
    end else begin
      mdl_step(0, 2);
      mdl_step(1, 1);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (nrst) begin
      check("d2 mean",   if2.mean_curr,   e_mean[0]);
      check("d2 peak",   if2.peak_curr,   e_peak[0]);
      check("d2 trough", if2.trough_curr, e_trough[0]);
      check("d2 valid",  if2.mean_valid,  e_valid[0]);
      check("d2 busy",   if2.busy,        m_phase[0] == 1);
      check("d1 mean",   if1.mean_curr,   e_mean[1]);
      check("d1 peak",   if1.peak_curr,   e_peak[1]);
      check("d1 trough", if1.trough_curr, e_trough[1]);
      check("d1 valid",  if1.mean_valid,  e_valid[1]);
      check("d1 busy",   if1.busy,        m_phase[1] == 1);
    end
  end

  // ---------------- directed helpers ----------------
  // Counts edges until dut2 pulses; 'start' is the offset of the last edge
  // already passed. Gives -1 if the budget runs out.
  task automatic wait_valid(input int start, output int off2, output int off1);
    int n;
    n = start; off2 = -1; off1 = -1;
    while (off2 < 0 && n < 40) begin
      @(posedge clk); n++; #1;
      if (off1 < 0 && if1.mean_valid) off1 = n;
      if (if2.mean_valid) off2 = n;
    end
  endtask

  // Presents win[k] on dut2's k-th strobe edge, then checks the publish edge.
  task automatic run_window(input string name, input logic [ADC_W-1:0] exp_mean,
                            input logic [ADC_W-1:0] exp_peak, input logic [ADC_W-1:0] exp_trough);
    measure = 1'b1;
    adc     = win[0];
    repeat (3) @(posedge clk);
    #1;
    for (int k = 1; k < NWIN; k++) begin
      adc = win[k];
      repeat (2) @(posedge clk);
      #1;
    end
    @(posedge clk); #1;
    check({name, " valid@17"}, if2.mean_valid,  1);
    check({name, " mean"},     if2.mean_curr,   exp_mean);
    check({name, " peak"},     if2.peak_curr,   exp_peak);
    check({name, " trough"},   if2.trough_curr, exp_trough);
    measure = 1'b0;
    @(posedge clk); #1;
    check({name, " valid off"}, if2.mean_valid, 0);
    check({name, " idle busy"}, if2.busy,       0);
  endtask

  task automatic stop_and_idle();
    measure = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int o2, o1;
    tests = 0; fails = 0;
    nrst = 1'b0; swipt_alive = 1'b1; measure = 1'b0; adc = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset mean",   if2.mean_curr,   0);
    check("reset peak",   if2.peak_curr,   0);
    check("reset trough", if2.trough_curr, 0);
    check("reset valid",  if2.mean_valid,  0);
    check("reset busy",   if2.busy,        0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // 1. constant 0x800, continuous measure; DECIM=1 instance pulses at t+9
    measure = 1'b1; adc = 12'h800;
    wait_valid(-1, o2, o1);
    check("s1 latency",   o2, 17);
    check("s1 d1 latency", o1, 9);
    check("s1 mean",   if2.mean_curr,   12'h800);
    check("s1 peak",   if2.peak_curr,   12'h800);
    check("s1 trough", if2.trough_curr, 12'h800);
    check("s1 d1 mean", if1.mean_curr,  12'h800);
    wait_valid(0, o2, o1);
    check("s1 back-to-back", o2, 17);
    stop_and_idle();

    // 2. ramp 0x010..0x080
    for (int k = 0; k < NWIN; k++) win[k] = ADC_W'(16 * (k + 1));
    run_window("s2 ramp", 12'h048, 12'h080, 12'h010);

    // 3. full scale, then truncation
    for (int k = 0; k < NWIN; k++) win[k] = 12'hFFF;
    run_window("s3 full", 12'hFFF, 12'hFFF, 12'hFFF);
    for (int k = 0; k < NWIN; k++) win[k] = 12'h001;
    win[NWIN-1] = 12'h002;
    run_window("s3 trunc", 12'h001, 12'h002, 12'h001);

    // 4. abort after a good 0x800 window
    for (int k = 0; k < NWIN; k++) win[k] = 12'h800;
    run_window("s4 prior", 12'h800, 12'h800, 12'h800);
    measure = 1'b1; adc = 12'h123;
    repeat (9) @(posedge clk);
    #1;
    measure = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("s4 busy",   if2.busy,        0);
    check("s4 valid",  if2.mean_valid,  0);
    check("s4 hold mean",   if2.mean_curr,   12'h800);
    check("s4 hold trough", if2.trough_curr, 12'h800);
    measure = 1'b1; adc = 12'h456;
    wait_valid(-1, o2, o1);
    check("s4 restart latency", o2, 17);
    check("s4 restart mean", if2.mean_curr, 12'h456);
    stop_and_idle();

    // 5. swiptAlive low mid-window
    measure = 1'b1; adc = 12'h321;
    repeat (7) @(posedge clk);
    #1;
    swipt_alive = 1'b0;
    @(posedge clk); #1;
    check("s5 mean",  if2.mean_curr,   0);
    check("s5 peak",  if2.peak_curr,   0);
    check("s5 trough", if2.trough_curr, 0);
    check("s5 busy",  if2.busy,        0);
    check("s5 valid", if2.mean_valid,  0);
    swipt_alive = 1'b1;
    wait_valid(-1, o2, o1);
    check("s5 restart latency", o2, 17);
    check("s5 restart mean", if2.mean_curr, 12'h321);
    stop_and_idle();

    // 6. asynchronous reset during DONE
    measure = 1'b1; adc = 12'h654;
    repeat (17) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    check("s6 async mean",  if2.mean_curr,  0);
    check("s6 async peak",  if2.peak_curr,  0);
    check("s6 async valid", if2.mean_valid, 0);
    check("s6 async busy",  if2.busy,       0);
    #2;
    nrst = 1'b1;
    wait_valid(-1, o2, o1);
    check("s6 restart latency", o2, 17);
    check("s6 restart mean", if2.mean_curr, 12'h654);
    stop_and_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
